// File: rtl/mem_size_probe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_size_probe_if                                                    |
// | Command/response bus between the size probe and a memory controller. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_size_probe_if #(
  parameter int AW = 27,
  parameter int DW = 16
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic          mem_ready;
  logic [DW-1:0] mem_dout;

  modport master (
    output mem_addr, mem_din, mem_we, mem_rd,
    input  mem_ready, mem_dout
  );

  modport slave (
    input  mem_addr, mem_din, mem_we, mem_rd,
    output mem_ready, mem_dout
  );
endinterface
`default_nettype wire

// File: rtl/mem_size_probe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_size_probe                                                       |
// | Detects installed memory size by aliasing probes, then zero-sweeps.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_size_probe #(
  parameter int AW       = 27,
  parameter int DW       = 16,
  parameter int NPROBE   = 3,
  parameter int PAT_BASE = 1032,
  parameter int PAT_STEP = 1032,
  parameter int CLR_AW   = 25,
  parameter int CLR_GAP  = 31,
  parameter int CLR_LOOP = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  mem_size_probe_if.master  mem,
  output logic [NPROBE-1:0] size_mask,
  output logic              size_valid,
  output logic              clr_active,
  output logic [7:0]        clr_passes
);
  localparam int KW = (NPROBE > 1) ? $clog2(NPROBE) : 1;
  localparam int GW = (CLR_GAP > 0) ? $clog2(CLR_GAP + 1) : 1;
  localparam logic [KW-1:0] K_TOP      = KW'(NPROBE - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(CLR_GAP - 1);
  localparam logic [AW-1:0] GUARD_ADDR = AW'(1) << (AW - NPROBE);
  localparam logic [DW-1:0] GUARD_PAT  = ~DW'(PAT_BASE);

  typedef enum logic [2:0] {S_WAIT_RDY, S_PWR, S_GWR, S_PRD, S_CLEAR, S_DONE} state_t;
  typedef enum logic [1:0] {PH_ISS, PH_SKIP, PH_WAIT, PH_GAP} phase_t;

  function automatic logic [AW-1:0] probe_addr(input logic [KW-1:0] k);
    probe_addr = (k == '0) ? '0 : (AW'(1) << (AW - NPROBE + int'(k)));
  endfunction

  function automatic logic [DW-1:0] probe_pat(input logic [KW-1:0] k);
    probe_pat = DW'(PAT_BASE + int'(k) * PAT_STEP);
  endfunction

  state_t              state_q, state_d;
  phase_t              ph_q, ph_d;
  logic [KW-1:0]       k_q, k_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [CLR_AW-1:0]   clr_addr_q, clr_addr_d;
  logic [7:0]          passes_q, passes_d;
  logic [NPROBE-1:0]   mask_q, mask_d;
  logic                valid_q, valid_d;
  logic                we_q, we_d, rd_q, rd_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       din_q, din_d;

  logic                w_done;
  logic                w_iss, w_iss_we;
  logic [AW-1:0]       w_iss_addr;
  logic [DW-1:0]       w_iss_din;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_WAIT_RDY;
      ph_q       <= PH_WAIT;
      k_q        <= '0;
      gap_q      <= '0;
      clr_addr_q <= '0;
      passes_q   <= '0;
      mask_q     <= '0;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      k_q        <= k_d;
      gap_q      <= gap_d;
      clr_addr_q <= clr_addr_d;
      passes_q   <= passes_d;
      mask_q     <= mask_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  // Completion is only recognised once the post-issue ignore cycle has passed.
  assign w_done = (ph_q == PH_WAIT) && mem.mem_ready;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    k_d        = k_q;
    gap_d      = gap_q;
    clr_addr_d = clr_addr_q;
    passes_d   = passes_q;
    mask_d     = mask_q;
    valid_d    = valid_q;
    we_d       = 1'b0;
    rd_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    w_iss      = 1'b0;
    w_iss_we   = 1'b1;
    w_iss_addr = '0;
    w_iss_din  = '0;

    case (ph_q)
      PH_ISS:  ph_d = PH_SKIP;
      PH_SKIP: ph_d = PH_WAIT;
      default: ;
    endcase

    case (state_q)
      S_WAIT_RDY: begin
        mask_d  = '0;
        valid_d = 1'b0;
        if (w_done) begin
          state_d    = S_PWR;
          k_d        = K_TOP;
          w_iss      = 1'b1;
          w_iss_addr = probe_addr(K_TOP);
          w_iss_din  = probe_pat(K_TOP);
        end
      end
      S_PWR: begin
        if (w_done) begin
          w_iss = 1'b1;
          if (k_q == '0) begin
            state_d    = S_GWR;
            w_iss_addr = GUARD_ADDR;
            w_iss_din  = GUARD_PAT;
          end else begin
            k_d        = k_q - KW'(1);
            w_iss_addr = probe_addr(k_d);
            w_iss_din  = probe_pat(k_d);
          end
        end
      end
      S_GWR: begin
        if (w_done) begin
          state_d    = S_PRD;
          k_d        = K_TOP;
          w_iss      = 1'b1;
          w_iss_we   = 1'b0;
          w_iss_addr = probe_addr(K_TOP);
        end
      end
      S_PRD: begin
        if (w_done) begin
          mask_d[k_q] = (mem.mem_dout == probe_pat(k_q));
          w_iss       = 1'b1;
          if (k_q == '0) begin
            valid_d    = 1'b1;
            state_d    = S_CLEAR;
            clr_addr_d = '0;
          end else begin
            k_d        = k_q - KW'(1);
            w_iss_we   = 1'b0;
            w_iss_addr = probe_addr(k_d);
          end
        end
      end
      S_CLEAR: begin
        if (w_done) begin
          if (&clr_addr_q && passes_q != 8'hFF) passes_d = passes_q + 8'd1;
          clr_addr_d = clr_addr_q + CLR_AW'(1);
          if (&clr_addr_q && CLR_LOOP == 0) begin
            state_d = S_DONE;
          end else if (CLR_GAP == 0) begin
            w_iss      = 1'b1;
            w_iss_addr = AW'(clr_addr_d);
          end else begin
            ph_d  = PH_GAP;
            gap_d = '0;
          end
        end else if (ph_q == PH_GAP) begin
          if (gap_q == GAP_LAST) begin
            w_iss      = 1'b1;
            w_iss_addr = AW'(clr_addr_q);
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: ;
    endcase

    if (w_iss) begin
      we_d   = w_iss_we;
      rd_d   = ~w_iss_we;
      addr_d = w_iss_addr;
      din_d  = w_iss_din;
      ph_d   = PH_ISS;
    end

    // A command seen by the controller this cycle still gets its ignore cycle.
    if (start) begin
      state_d    = S_WAIT_RDY;
      ph_d       = (we_q | rd_q) ? PH_SKIP : PH_WAIT;
      k_d        = '0;
      gap_d      = '0;
      clr_addr_d = '0;
      passes_d   = '0;
      mask_d     = '0;
      valid_d    = 1'b0;
      we_d       = 1'b0;
      rd_d       = 1'b0;
      addr_d     = '0;
      din_d      = '0;
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_din  = din_q;
  assign mem.mem_we   = we_q;
  assign mem.mem_rd   = rd_q;
  assign size_mask    = mask_q;
  assign size_valid   = valid_q;
  assign clr_active   = (state_q == S_CLEAR);
  assign clr_passes   = passes_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_size_probe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_size_probe                                                    |
// | Directed bench with a sparse one-cycle-busy memory controller model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_size_probe;
  localparam int AW = 27;
  localparam int DW = 16;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic [2:0] size_mask;
  logic       size_valid, clr_active;
  logic [7:0] clr_passes;

  mem_size_probe_if #(.AW(AW), .DW(DW)) mif ();

  mem_size_probe #(
    .AW(AW), .DW(DW), .NPROBE(3), .PAT_BASE(1032), .PAT_STEP(1032),
    .CLR_AW(4), .CLR_GAP(2), .CLR_LOOP(0)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (start),
    .mem       (mif),
    .size_mask (size_mask),
    .size_valid(size_valid),
    .clr_active(clr_active),
    .clr_passes(clr_passes)
  );

  always #5 clk_sys = ~clk_sys;

  // Memory model: only the probe/guard bits [26:24] and low bits [3:0] are ever used.
  logic          alias_en  = 1'b0;
  logic          force_low = 1'b0;
  logic          rdy_q     = 1'b1;
  logic          busy_q    = 1'b0;
  logic [DW-1:0] dout_q    = '0;
  logic [DW-1:0] mem_arr [128];
  logic [AW-1:0] w_key;
  logic [6:0]    w_slot;
  int            cyc = 0, both_err = 0, addr_err = 0, cmd_cnt = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    int            cyc;
    logic          clr;
  } wr_t;
  wr_t wlog[$];

  assign w_key  = alias_en ? (mif.mem_addr & 27'h1FF_FFFF) : mif.mem_addr;
  assign w_slot = {w_key[26:24], w_key[3:0]};
  assign mif.mem_ready = rdy_q & ~force_low;
  assign mif.mem_dout  = dout_q;

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (mif.mem_we || mif.mem_rd) begin
      cmd_cnt <= cmd_cnt + 1;
      if (mif.mem_we && mif.mem_rd) both_err <= both_err + 1;
      if ((w_key & 27'h0FF_FFF0) != '0) addr_err <= addr_err + 1;
      if (mif.mem_we) wlog.push_back(wr_t'{mif.mem_addr, mif.mem_din, cyc, clr_active});
    end
    if (busy_q) begin
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
    end else if (rdy_q && (mif.mem_we || mif.mem_rd)) begin
      if (mif.mem_we) mem_arr[w_slot] <= mif.mem_din;
      else            dout_q <= mem_arr[w_slot];
      rdy_q  <= 1'b0;
      busy_q <= 1'b1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!size_valid && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq({tag, "_valid"}, 64'(size_valid), 64'd1);
  endtask

  task automatic wait_rd(input string tag);
    int n = 0;
    while (!mif.mem_rd && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq({tag, "_rd_seen"}, 64'(mif.mem_rd), 64'd1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  initial begin
    int w0, n, cmd0, bad_ord, bad_gap;

    repeat (3) @(negedge clk_sys);
    check_eq("rst_we",     64'(mif.mem_we),   64'd0);
    check_eq("rst_rd",     64'(mif.mem_rd),   64'd0);
    check_eq("rst_addr",   64'(mif.mem_addr), 64'd0);
    check_eq("rst_din",    64'(mif.mem_din),  64'd0);
    check_eq("rst_mask",   64'(size_mask),    64'd0);
    check_eq("rst_valid",  64'(size_valid),   64'd0);
    check_eq("rst_active", 64'(clr_active),   64'd0);
    check_eq("rst_passes", 64'(clr_passes),   64'd0);

    // Full-size memory: every probe survives.
    w0 = wlog.size();
    reset = 1'b0;
    wait_valid("run1");
    check_eq("run1_mask", 64'(size_mask), 64'h7);
    check_eq("run1_w0_addr", 64'(wlog[w0].addr),   64'h400_0000);
    check_eq("run1_w0_din",  64'(wlog[w0].din),    64'd3096);
    check_eq("run1_w1_addr", 64'(wlog[w0+1].addr), 64'h200_0000);
    check_eq("run1_w1_din",  64'(wlog[w0+1].din),  64'd2064);
    check_eq("run1_w2_addr", 64'(wlog[w0+2].addr), 64'h0);
    check_eq("run1_w2_din",  64'(wlog[w0+2].din),  64'd1032);
    check_eq("run1_g_addr",  64'(wlog[w0+3].addr), 64'h100_0000);
    check_eq("run1_g_din",   64'(wlog[w0+3].din),  64'hFBF7);

    n = 0;
    while ((clr_active || wlog.size() < w0 + 20) && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("clr_done_active", 64'(clr_active), 64'd0);
    check_eq("clr_count", 64'(wlog.size() - w0), 64'd20);
    bad_ord = 0;
    bad_gap = 0;
    for (int i = 0; i < 16; i++) begin
      if (wlog[w0+4+i].addr != 27'(i) || wlog[w0+4+i].din != '0 || !wlog[w0+4+i].clr) bad_ord++;
      if (i > 0 && (wlog[w0+4+i].cyc - wlog[w0+3+i].cyc) != 5) bad_gap++;
    end
    check_eq("clr_order",   64'(bad_ord),    64'd0);
    check_eq("clr_spacing", 64'(bad_gap),    64'd0);
    check_eq("clr_passes",  64'(clr_passes), 64'd1);

    cmd0 = cmd_cnt;
    repeat (30) @(negedge clk_sys);
    check_eq("done_idle",  64'(cmd_cnt - cmd0), 64'd0);
    check_eq("done_mask",  64'(size_mask),      64'h7);
    check_eq("done_valid", 64'(size_valid),     64'd1);

    // Aliasing memory: only probe 0 keeps its pattern.
    alias_en = 1'b1;
    pulse_start();
    check_eq("start_valid",  64'(size_valid), 64'd0);
    check_eq("start_passes", 64'(clr_passes), 64'd0);
    check_eq("start_mask",   64'(size_mask),  64'd0);
    wait_valid("alias");
    check_eq("alias_mask", 64'(size_mask), 64'h1);

    n = 0;
    while (!(mif.mem_we && clr_active && mif.mem_addr == 27'd7) && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("clr7_seen", {mif.mem_we, clr_active, 34'd0, mif.mem_addr}, {2'b11, 34'd0, 27'd7});
    alias_en = 1'b0;
    pulse_start();
    w0 = wlog.size();
    check_eq("midclr_valid",  64'(size_valid), 64'd0);
    check_eq("midclr_passes", 64'(clr_passes), 64'd0);
    check_eq("midclr_active", 64'(clr_active), 64'd0);
    check_eq("midclr_we",     64'(mif.mem_we), 64'd0);
    n = 0;
    while (wlog.size() <= w0 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("restart_addr", 64'(wlog[w0].addr), 64'h400_0000);
    check_eq("restart_din",  64'(wlog[w0].din),  64'd3096);

    // Controller stalls during the first probe read.
    wait_rd("stall");
    @(negedge clk_sys);
    force_low = 1'b1;
    cmd0 = cmd_cnt;
    repeat (100) @(negedge clk_sys);
    check_eq("stall_cmds",  64'(cmd_cnt - cmd0), 64'd0);
    check_eq("stall_addr",  64'(mif.mem_addr),   64'h400_0000);
    check_eq("stall_rd",    64'(mif.mem_rd),     64'd0);
    check_eq("stall_mask",  64'(size_mask),      64'd0);
    check_eq("stall_valid", 64'(size_valid),     64'd0);
    force_low = 1'b0;
    wait_valid("stall");
    check_eq("stall_end_mask", 64'(size_mask), 64'h7);

    // Reset while the final probe read is pending.
    pulse_start();
    for (int r = 0; r < 3; r++) begin
      wait_rd("prerst");
      @(negedge clk_sys);
    end
    check_eq("prerst_mask", 64'(size_mask), 64'h6);
    reset = 1'b1;
    #1;
    check_eq("arst_rd",     64'(mif.mem_rd),   64'd0);
    check_eq("arst_addr",   64'(mif.mem_addr), 64'd0);
    check_eq("arst_mask",   64'(size_mask),    64'd0);
    check_eq("arst_valid",  64'(size_valid),   64'd0);
    check_eq("arst_active", 64'(clr_active),   64'd0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
    check_eq("postrst_mask", 64'(size_mask), 64'd0);
    wait_valid("postrst");
    check_eq("postrst_final_mask", 64'(size_mask), 64'h7);

    check_eq("bus_both_we_rd", 64'(both_err), 64'd0);
    check_eq("bus_addr_range", 64'(addr_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
